// File: rtl/adsr32.sv
// adsr32: linear ADSR envelope generator.
// Produces the 32-bit unsigned VCA control word. The envelope advances one
// step per sample-rate strobe and walks IDLE -> ATTACK -> DECAY -> SUSTAIN
// -> RELEASE from the gate input. Slopes and the sustain level are live
// inputs and are only looked at on strobe clocks.
module adsr32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_en,
   input  logic             gate,
   input  logic [WIDTH-1:0] attack_inc,
   input  logic [WIDTH-1:0] decay_dec,
   input  logic [WIDTH-1:0] sustain_lvl,
   input  logic [WIDTH-1:0] release_dec,
   output logic [WIDTH-1:0] cv,
   output logic [2:0]       state,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   localparam logic [WIDTH-1:0] CV_MAX = '1;

   state_t           cur_st;
   state_t           nxt_st;
   logic [WIDTH-1:0] nxt_cv;

   // Slope arithmetic, shared by the next-state logic below.
   logic [WIDTH:0]   att_sum;   // one extra bit keeps the attack carry
   logic             att_sat;   // attack reached or passed full scale
   logic [WIDTH-1:0] dec_diff;
   logic             dec_hit;   // decay reached (or undershot) sustain
   logic [WIDTH-1:0] rel_diff;
   logic             rel_hit;   // release would reach or cross zero

   assign state = cur_st;

   // Attack saturates on carry or an all-ones result; decay and release
   // treat underflow as having reached their target.
   always_comb begin
      att_sum  = {1'b0, cv} + {1'b0, attack_inc};
      att_sat  = att_sum[WIDTH] | (&att_sum[WIDTH-1:0]);
      dec_diff = cv - decay_dec;
      dec_hit  = (cv <= decay_dec) || (dec_diff <= sustain_lvl);
      rel_diff = cv - release_dec;
      rel_hit  = (cv <= release_dec);
   end

   // Next phase and next envelope value for the coming tick.
   always_comb begin
      nxt_st = cur_st;
      nxt_cv = cv;
      case (cur_st)
         S_IDLE: begin
            if (gate) nxt_st = S_ATTACK;
         end
         S_ATTACK: begin
            if (!gate) begin
               nxt_st = S_RELEASE;
            end else if (att_sat) begin
               nxt_cv = CV_MAX;
               nxt_st = S_DECAY;
            end else begin
               nxt_cv = att_sum[WIDTH-1:0];
            end
         end
         S_DECAY: begin
            if (!gate) begin
               nxt_st = S_RELEASE;
            end else if (dec_hit) begin
               nxt_cv = sustain_lvl;
               nxt_st = S_SUSTAIN;
            end else begin
               nxt_cv = dec_diff;
            end
         end
         S_SUSTAIN: begin
            // level is re-sampled every tick so live edits are tracked
            if (!gate) nxt_st = S_RELEASE;
            else       nxt_cv = sustain_lvl;
         end
         S_RELEASE: begin
            // retrigger resumes attack from the current level
            if (gate) begin
               nxt_st = S_ATTACK;
            end else if (rel_hit) begin
               nxt_cv = '0;
               nxt_st = S_IDLE;
            end else begin
               nxt_cv = rel_diff;
            end
         end
         default: begin
            nxt_cv = '0;
            nxt_st = S_IDLE;
         end
      endcase
   end

   // Registered outputs; only strobe clocks move the envelope.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_st <= S_IDLE;
         cv     <= '0;
         busy   <= 1'b0;
      end else if (sample_en) begin
         cur_st <= nxt_st;
         cv     <= nxt_cv;
         busy   <= (nxt_st != S_IDLE);
      end
   end

endmodule

// File: tb/tb_adsr32.sv
// tb_adsr32: randomized + directed bench for adsr32 with a behavioural
// envelope model checked on every clock.
module tb_adsr32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_en = 1'b0;
   logic        gate = 1'b0;
   logic [31:0] attack_inc = '0;
   logic [31:0] decay_dec = '0;
   logic [31:0] sustain_lvl = '0;
   logic [31:0] release_dec = '0;
   logic [31:0] cv;
   logic [2:0]  state;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // behavioural model: phase number and level
   int          m_st = 0;
   logic [31:0] m_cv = '0;

   adsr32 #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .gate(gate),
      .attack_inc(attack_inc), .decay_dec(decay_dec),
      .sustain_lvl(sustain_lvl), .release_dec(release_dec),
      .cv(cv), .state(state), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // model update from the envelope rules, in plain arithmetic
   task automatic model_tick();
      longint unsigned sum;
      case (m_st)
         0: if (gate) m_st = 1;
         1: begin
            if (!gate) m_st = 4;
            else begin
               sum = longint'(m_cv) + longint'(attack_inc);
               if (sum >= 64'hFFFF_FFFF) begin m_cv = 32'hFFFF_FFFF; m_st = 2; end
               else m_cv = sum[31:0];
            end
         end
         2: begin
            if (!gate) m_st = 4;
            else if (m_cv <= decay_dec || (m_cv - decay_dec) <= sustain_lvl) begin
               m_cv = sustain_lvl; m_st = 3;
            end else m_cv = m_cv - decay_dec;
         end
         3: begin
            if (!gate) m_st = 4;
            else m_cv = sustain_lvl;
         end
         default: begin
            if (gate) m_st = 1;
            else if (m_cv <= release_dec) begin m_cv = 0; m_st = 0; end
            else m_cv = m_cv - release_dec;
         end
      endcase
   endtask

   always @(negedge rst_n) begin
      m_st = 0;
      m_cv = '0;
   end

   // compare process: advance model on ticks, check just after every edge
   always @(posedge clk) begin
      if (rst_n && sample_en) model_tick();
      #1;
      chk("cmp_cv", cv, m_cv);
      chk("cmp_state", {29'd0, state}, m_st[31:0]);
      chk("cmp_busy", {31'd0, busy}, {31'd0, m_st != 0});
   end

   // one strobe with the given gate, ending at the following negedge
   task automatic tick(input logic g);
      gate = g;
      sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
   endtask

   task automatic expect_st(input string nm, input logic [31:0] ecv, input int est);
      chk({nm, "_cv"}, cv, ecv);
      chk({nm, "_st"}, {29'd0, state}, est[31:0]);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_cv", cv, 32'h0);
      chk("rst_st", {29'd0, state}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return $urandom_range(1, 32'h00FF_FFFF);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // async reset mid-attack
      attack_inc = 32'h4000_0000;
      tick(1); tick(1); tick(1);
      expect_st("pre_rst", 32'h8000_0000, 1);
      do_reset();
      tick(0); tick(0);
      expect_st("idle_hold", 32'h0, 0);

      // full ADSR sequence
      attack_inc = 32'h4000_0000; decay_dec = 32'h4000_0000;
      sustain_lvl = 32'h8000_0000; release_dec = 32'h3000_0000;
      tick(1); expect_st("a0", 32'h0, 1);
      tick(1); expect_st("a1", 32'h4000_0000, 1);
      tick(1); expect_st("a2", 32'h8000_0000, 1);
      tick(1); expect_st("a3", 32'hC000_0000, 1);
      tick(1); expect_st("a4", 32'hFFFF_FFFF, 2);
      tick(1); expect_st("d1", 32'hBFFF_FFFF, 2);
      tick(1); expect_st("s0", 32'h8000_0000, 3);
      chk("s0_busy", {31'd0, busy}, 32'd1);
      tick(0); expect_st("r0", 32'h8000_0000, 4);
      tick(0); expect_st("r1", 32'h5000_0000, 4);
      tick(0); expect_st("r2", 32'h2000_0000, 4);
      tick(0); expect_st("r3", 32'h0, 0);
      chk("r3_busy", {31'd0, busy}, 32'd0);

      // retrigger from release
      repeat (7) tick(1);
      tick(0); tick(0);
      expect_st("rt_pre", 32'h5000_0000, 4);
      tick(1); expect_st("rt0", 32'h5000_0000, 1);
      tick(1); expect_st("rt1", 32'h9000_0000, 1);
      tick(0); expect_st("rt2", 32'h9000_0000, 4);

      // strobe gating: gate toggles with no strobe
      for (int i = 0; i < 100; i++) begin
         gate = ~gate;
         @(negedge clk);
      end
      expect_st("gated", 32'h9000_0000, 4);
      tick(1); expect_st("one_strobe", 32'h9000_0000, 1);

      // saturation and sustain at full scale
      do_reset();
      attack_inc = 32'hFFFF_FFFF; sustain_lvl = 32'hFFFF_FFFF;
      tick(1); expect_st("sat0", 32'h0, 1);
      tick(1); expect_st("sat1", 32'hFFFF_FFFF, 2);
      tick(1); expect_st("susmax", 32'hFFFF_FFFF, 3);
      sustain_lvl = 32'h1234_0000;
      tick(1); expect_st("live_sus", 32'h1234_0000, 3);

      // sustain at zero holds in SUSTAIN
      do_reset();
      sustain_lvl = 32'h0; decay_dec = 32'h9000_0000;
      tick(1); tick(1); expect_st("z0", 32'hFFFF_FFFF, 2);
      tick(1); expect_st("z1", 32'h6FFF_FFFF, 2);
      tick(1); expect_st("z2", 32'h0, 3);
      chk("z2_busy", {31'd0, busy}, 32'd1);

      // randomized run, model checked every clock by the compare process
      for (int i = 0; i < 4000; i++) begin
         sample_en = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 15) == 0) gate = ~gate;
         if ($urandom_range(0, 30) == 0) attack_inc = rnd_val();
         if ($urandom_range(0, 30) == 0) decay_dec = rnd_val();
         if ($urandom_range(0, 30) == 0) sustain_lvl = rnd_val();
         if ($urandom_range(0, 30) == 0) release_dec = rnd_val();
         if ($urandom_range(0, 600) == 0) begin
            sample_en = 1'b0;
            do_reset();
         end else begin
            @(negedge clk);
         end
      end

      sample_en = 1'b0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
